// File: rtl/sdft_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdft_scheduler_pkg
//   Shared state encoding and default geometry constants used by the SDFT,
//   waterfall BRAM and display blocks.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package sdft_scheduler_pkg;

  localparam int unsigned DEF_FREQ_BINS  = 64;
  localparam int unsigned DEF_LIMIT_BINS = 32;
  localparam int unsigned DEF_ROWS       = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SWEEP = 2'd2,
    S_DRAIN = 2'd3
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/sdft_scheduler_bram_write_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bram_write_arb
//   Freq BRAM write port arbiter. The display reader (rd_en_i) always wins;
//   a magnitude that collides with a read is parked in a 1-deep hold
//   register and written on the first cycle without a read.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module bram_write_arb #(
  parameter int DATA_W  = 16,
  parameter int BRAM_AW = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_i,
  input  logic [BRAM_AW-1:0] req_addr_i,
  input  logic [DATA_W-1:0]  req_data_i,
  input  logic               rd_en_i,
  output logic               hold_full_o,
  output logic               wr_en_o,
  output logic [BRAM_AW-1:0] wr_addr_o,
  output logic [DATA_W-1:0]  wr_data_o
);

  logic               hold_full_q;
  logic [BRAM_AW-1:0] hold_addr_q;
  logic [DATA_W-1:0]  hold_data_q;

  // Park a request that loses to a read; release it once the read ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_q <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else if (req_i && rd_en_i) begin
      hold_full_q <= 1'b1;
      hold_addr_q <= req_addr_i;
      hold_data_q <= req_data_i;
    end else if (hold_full_q && !rd_en_i) begin
      hold_full_q <= 1'b0;
    end
  end

  // Drive the write port: held data first, else a direct write; zero when idle.
  // A new request never coincides with a full hold because the scheduler
  // stops issuing bins while the hold is occupied.
  always_comb begin
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (!rd_en_i) begin
      if (hold_full_q) begin
        wr_en_o   = 1'b1;
        wr_addr_o = hold_addr_q;
        wr_data_o = hold_data_q;
      end else if (req_i) begin
        wr_en_o   = 1'b1;
        wr_addr_o = req_addr_i;
        wr_data_o = req_data_i;
      end
    end
  end

  assign hold_full_o = hold_full_q;

endmodule
`default_nettype wire

// File: rtl/sdft_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdft_scheduler
//   Per-sample sequencer for the sliding-DFT: loads the new ADC sample,
//   sweeps all bins through the SDFT with a valid/ready handshake, and on
//   every DECIMATE-th sample stores bins 0..LIMIT_BINS-1 into one waterfall
//   row of the freq BRAM.
//   Optional feature macro: SDFT_SCHED_STATS_EN (saturating overrun counter;
//   when undefined overrun_count is tied to 0).
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module sdft_scheduler
  import sdft_scheduler_pkg::*;
#(
  parameter int FREQ_BINS  = DEF_FREQ_BINS,
  parameter int LIMIT_BINS = DEF_LIMIT_BINS,
  parameter int ROWS       = DEF_ROWS,
  parameter int DECIMATE   = 16,
  parameter int DATA_W     = 16,
  parameter int BIN_W      = $clog2(FREQ_BINS),
  parameter int ROW_W      = $clog2(ROWS),
  parameter int BRAM_AW    = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_valid,
  input  logic [DATA_W-1:0]  sample_in,
  output logic               sdft_start,
  output logic [DATA_W-1:0]  sdft_sample,
  output logic               bin_valid,
  output logic [BIN_W-1:0]   bin_idx,
  input  logic               bin_ready,
  input  logic               mag_valid,
  input  logic [DATA_W-1:0]  mag_in,
  input  logic               rd_en,
  output logic               wr_en,
  output logic [BRAM_AW-1:0] wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic [ROW_W-1:0]   row_ptr,
  output logic               row_done,
  output logic [7:0]         overrun_count
);

  localparam int             CNT_W   = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [BIN_W:0] LIMIT_L = (BIN_W+1)'(LIMIT_BINS);

  sched_state_e       state_q, state_d;
  logic [DATA_W-1:0]  sample_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BIN_W-1:0]   mag_bin_q;   // bin whose magnitude is outstanding
  logic               pending_q;
  logic [CNT_W-1:0]   sample_cnt_q;
  logic [ROW_W-1:0]   row_ptr_q;

  logic               hold_full;
  logic               accept;
  logic               last_bin;
  logic               capture;
  logic               drain_exit;
  logic               store_req;
  logic [BRAM_AW-1:0] store_addr;

  assign capture    = (sample_cnt_q == CNT_W'(DECIMATE - 1));
  assign bin_valid  = (state_q == S_SWEEP) && !pending_q && !hold_full;
  assign accept     = bin_valid && bin_ready;
  assign last_bin   = (bin_q == BIN_W'(FREQ_BINS - 1));
  assign drain_exit = (state_q == S_DRAIN) && !pending_q && !hold_full;
  // pending_q gates mag_valid so stray returns outside a sweep are ignored
  assign store_req  = mag_valid && pending_q && capture && ({1'b0, mag_bin_q} < LIMIT_L);
  assign store_addr = BRAM_AW'(row_ptr_q) * BRAM_AW'(LIMIT_BINS) + BRAM_AW'(mag_bin_q);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode plus the one-cycle start and row-commit pulses.
  always_comb begin
    state_d    = state_q;
    sdft_start = 1'b0;
    row_done   = 1'b0;
    case (state_q)
      S_IDLE:  if (sample_valid) state_d = S_START;
      S_START: begin
        sdft_start = 1'b1;
        state_d    = S_SWEEP;
      end
      S_SWEEP: if (accept && last_bin) state_d = S_DRAIN;
      S_DRAIN: if (drain_exit) begin
        state_d  = S_IDLE;
        row_done = capture;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sample latch, bin sweep counter, outstanding-bin tracking, row bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q     <= '0;
      bin_q        <= '0;
      mag_bin_q    <= '0;
      pending_q    <= 1'b0;
      sample_cnt_q <= '0;
      row_ptr_q    <= '0;
    end else begin
      if ((state_q == S_IDLE) && sample_valid) sample_q <= sample_in;

      if (state_q == S_START) begin
        bin_q <= '0;
      end else if (accept) begin
        mag_bin_q <= bin_q;
        bin_q     <= bin_q + 1'b1;
      end

      if (accept)         pending_q <= 1'b1;
      else if (mag_valid) pending_q <= 1'b0;

      if (drain_exit) begin
        sample_cnt_q <= capture ? '0 : sample_cnt_q + 1'b1;
        if (capture) begin
          row_ptr_q <= (row_ptr_q == ROW_W'(ROWS - 1)) ? '0 : row_ptr_q + 1'b1;
        end
      end
    end
  end

  assign sdft_sample = sample_q;
  assign bin_idx     = bin_q;
  assign row_ptr     = row_ptr_q;

  bram_write_arb #(
    .DATA_W  (DATA_W),
    .BRAM_AW (BRAM_AW)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (store_req),
    .req_addr_i  (store_addr),
    .req_data_i  (mag_in),
    .rd_en_i     (rd_en),
    .hold_full_o (hold_full),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data)
  );

`ifdef SDFT_SCHED_STATS_EN
  logic [7:0] ovr_q;

  // Count samples arriving while busy, saturating at 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= 8'd0;
    end else if (sample_valid && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_q <= ovr_q + 8'd1;
    end
  end

  assign overrun_count = ovr_q;
`else
  assign overrun_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdft_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdft_scheduler
//   Directed bench for sdft_scheduler (FREQ_BINS=64, LIMIT_BINS=32, ROWS=10,
//   DECIMATE=16) with a behavioural one-cycle-latency SDFT model.
//   Honours SDFT_SCHED_STATS_EN for the overrun expectation.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_sdft_scheduler;

`ifdef SDFT_SCHED_STATS_EN
  localparam int EXP_OVR = 255;
`else
  localparam int EXP_OVR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        sdft_start;
  logic [15:0] sdft_sample;
  logic        bin_valid;
  logic [5:0]  bin_idx;
  logic        bin_ready;
  logic        mag_valid;
  logic [15:0] mag_in;
  logic        rd_en;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  row_ptr;
  logic        row_done;
  logic [7:0]  overrun_count;

  sdft_scheduler #(
    .FREQ_BINS (64), .LIMIT_BINS (32), .ROWS (10), .DECIMATE (16),
    .DATA_W (16), .BIN_W (6), .ROW_W (4), .BRAM_AW (9)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .sample_valid (sample_valid), .sample_in (sample_in),
    .sdft_start (sdft_start), .sdft_sample (sdft_sample),
    .bin_valid (bin_valid), .bin_idx (bin_idx), .bin_ready (bin_ready),
    .mag_valid (mag_valid), .mag_in (mag_in), .rd_en (rd_en),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .row_ptr (row_ptr), .row_done (row_done), .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state (written only by the monitor process)
  int          cyc = 0;
  int          sweep_no = 0;
  int          acc_cnt = 0;
  int          wr_cnt = 0;
  int          addr_err = 0;
  int          rdone_cnt = 0;
  int          start_cyc = 0;
  int          first_acc_cyc = -1;
  int          last_acc_cyc = -1;
  int          first_wr_cyc = -1;
  int          rdone_cyc = -1;
  int          first_bin = -1;
  logic [15:0] got_sample = '0;

  // Stimulus-side state
  int          exp_base = 0;
  int          mptr = 0;
  int          n_samp = 0;
  int          bv_in_rd = 0;

  typedef struct {
    int groups;
    int rd_start;
    int rd_len;
    int exp_first_wr;
    int exp_last_acc;
    int exp_ptr;
  } vec_t;
  vec_t tbl[6];

  // SDFT model: magnitude one cycle after each accept, tagged with sweep and bin
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_valid <= 1'b0;
      mag_in    <= '0;
    end else begin
      mag_valid <= bin_valid && bin_ready;
      if (bin_valid && bin_ready) mag_in <= {sweep_no[7:0], 2'b10, bin_idx};
    end
  end

  // Monitor on the falling edge: event counts, timing and write scoreboard
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sdft_start) begin
      sweep_no      <= sweep_no + 1;
      start_cyc     <= cyc;
      acc_cnt       <= 0;
      wr_cnt        <= 0;
      addr_err      <= 0;
      rdone_cnt     <= 0;
      first_acc_cyc <= -1;
      first_wr_cyc  <= -1;
      got_sample    <= sdft_sample;
    end else begin
      if (bin_valid && bin_ready) begin
        if (acc_cnt == 0) begin
          first_acc_cyc <= cyc;
          first_bin     <= int'(bin_idx);
        end
        acc_cnt      <= acc_cnt + 1;
        last_acc_cyc <= cyc;
      end
      if (wr_en) begin
        if (wr_cnt == 0) first_wr_cyc <= cyc;
        if ((int'(wr_addr) != exp_base + wr_cnt) ||
            (wr_data != {sweep_no[7:0], 2'b10, wr_cnt[5:0]})) addr_err <= addr_err + 1;
        wr_cnt <= wr_cnt + 1;
      end
      if (row_done) begin
        rdone_cnt <= rdone_cnt + 1;
        rdone_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] out_vec();
    return {1'b0, sdft_start, sdft_sample, bin_valid, bin_idx, wr_en, wr_addr,
            wr_data, row_ptr, row_done, overrun_count};
  endfunction

  // One sample: pulse sample_valid, optionally raise rd_en for rd_len cycles
  // starting rd_start cycles after the sample, and return at the first IDLE cycle.
  task automatic run_sweep(input int rd_start, input int rd_len, output int s);
    int s0;
    int k;
    s0 = sweep_no;
    n_samp++;
    sample_in    = 16'h1000 + n_samp[15:0];
    sample_valid = 1'b1;
    s            = cyc;
    bv_in_rd     = 0;
    tick();
    sample_valid = 1'b0;
    k = 1;
    while (!(sweep_no != s0 && acc_cnt == 64) && k < 2000) begin
      rd_en = (rd_len > 0) && (k >= rd_start) && (k < rd_start + rd_len);
      #3;
      if (k > rd_start && k <= rd_start + rd_len && bin_valid) bv_in_rd++;
      tick();
      k++;
    end
    rd_en = 1'b0;
    chk("sweep_completes", 64'(k < 2000), 64'd1);
    tick();
    tick();
  endtask

  task automatic nc_sweep();
    int s;
    run_sweep(0, 0, s);
    chk("nocap_writes", 64'(wr_cnt), 64'd0);
    chk("nocap_row_done", 64'(rdone_cnt), 64'd0);
    chk("nocap_last_accept", 64'(last_acc_cyc - s), 64'd128);
  endtask

  task automatic cap_sweep(input int rd_start, input int rd_len,
                           input int exp_first_wr, input int exp_last);
    int s;
    exp_base = mptr * 32;
    run_sweep(rd_start, rd_len, s);
    chk("cap_start_latency", 64'(start_cyc - s), 64'd1);
    chk("cap_first_accept", 64'(first_acc_cyc - s), 64'd2);
    chk("cap_sdft_sample", 64'(got_sample), 64'(sample_in));
    chk("cap_first_bin", 64'(first_bin), 64'd0);
    chk("cap_accepts", 64'(acc_cnt), 64'd64);
    chk("cap_writes", 64'(wr_cnt), 64'd32);
    chk("cap_addr_data_errs", 64'(addr_err), 64'd0);
    chk("cap_first_write", 64'(first_wr_cyc - s), 64'(exp_first_wr));
    chk("cap_last_accept", 64'(last_acc_cyc - s), 64'(exp_last));
    chk("cap_row_done_count", 64'(rdone_cnt), 64'd1);
    chk("cap_row_done_cycle", 64'(rdone_cyc - s), 64'(exp_last + 2));
    chk("cap_bin_valid_in_hold", 64'(bv_in_rd), 64'd0);
    mptr = (mptr + 1) % 10;
    chk("cap_row_ptr", 64'(row_ptr), 64'(mptr));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int s0;
    int k;
    tbl[0] = '{1, 0, 0, 3, 128, 1};   // plain capture row 0
    tbl[1] = '{1, 3, 5, 8, 133, 2};   // 5-cycle read over bin 0 magnitude
    tbl[2] = '{1, 3, 1, 4, 129, 3};   // 1-cycle read over bin 0 magnitude
    tbl[3] = '{1, 2, 1, 3, 128, 4};   // read on an accept cycle: no stall
    tbl[4] = '{6, 0, 0, 3, 128, 0};   // rows 4..9, pointer wraps to 0
    tbl[5] = '{1, 0, 0, 3, 128, 1};   // 11th row lands on row 0 again

    sample_valid = 1'b0;
    sample_in    = '0;
    bin_ready    = 1'b1;
    rd_en        = 1'b0;
    reset_n      = 1'b0;
    repeat (3) tick();
    chk("reset_outputs_zero", out_vec(), 64'd0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a capture sweep (row_ptr is 0 before and after)
    for (int i = 0; i < 15; i++) nc_sweep();
    exp_base = 0;
    s0 = sweep_no;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    k = 0;
    while (!(sweep_no != s0 && acc_cnt == 20) && k < 500) begin
      tick();
      k++;
    end
    chk("abort_reached_bin20", 64'(k < 500), 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("abort_outputs_zero", out_vec(), 64'd0);
    chk("abort_partial_writes", 64'(wr_cnt), 64'd19);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    run_sweep(0, 0, s);
    chk("restart_first_bin", 64'(first_bin), 64'd0);
    chk("restart_accepts", 64'(acc_cnt), 64'd64);
    chk("restart_writes", 64'(wr_cnt), 64'd0);
    chk("restart_row_done", 64'(rdone_cnt), 64'd0);
    chk("restart_row_ptr", 64'(row_ptr), 64'd0);

    // Fresh start for the row table
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    mptr = 0;

    for (int v = 0; v < 6; v++) begin
      for (int g = 0; g < tbl[v].groups; g++) begin
        for (int i = 0; i < 15; i++) nc_sweep();
        cap_sweep(tbl[v].rd_start, tbl[v].rd_len, tbl[v].exp_first_wr, tbl[v].exp_last_acc);
      end
      chk("table_row_ptr", 64'(row_ptr), 64'(tbl[v].exp_ptr));
    end

    // 300 samples dropped while the sweep is stalled on bin_ready
    s0 = sweep_no;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (4) tick();
    bin_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    bin_ready    = 1'b1;
    k = 0;
    while (!(sweep_no != s0 && acc_cnt == 64) && k < 2000) begin
      tick();
      k++;
    end
    chk("ovr_sweep_completes", 64'(k < 2000), 64'd1);
    tick();
    tick();
    chk("ovr_count", 64'(overrun_count), 64'(EXP_OVR));
    chk("ovr_sweep_accepts", 64'(acc_cnt), 64'd64);
    chk("ovr_sweep_first_bin", 64'(first_bin), 64'd0);
    chk("ovr_sweep_writes", 64'(wr_cnt), 64'd0);
    chk("ovr_row_ptr", 64'(row_ptr), 64'd1);
    nc_sweep();
    chk("ovr_count_after", 64'(overrun_count), 64'(EXP_OVR));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
